// File: rtl/mmio_pkg.sv
// Shared types, register offsets and STATUS packing for the MMIO console block.
package mmio_pkg;

  localparam logic [3:0] CONSOLE_STATUS_OFS = 4'h4;
  localparam logic [3:0] CONSOLE_TX_OFS     = 4'h8;
  localparam logic [3:0] HALT_OFS           = 4'hC;
  localparam logic [3:0] FULL_WORD_WRITE    = 4'b1111;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic        do_read;
    logic [3:0]  do_write;
    logic [7:0]  user_tag;
  } memory_io_req;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  user_tag;
  } memory_io_rsp;

  typedef struct packed {
    logic [15:0] ovf_cnt;
    logic [5:0]  rsvd;
    logic        empty;
    logic        full;
    logic [7:0]  occupancy;
  } console_status_t;

  function automatic console_status_t pack_status(input logic [31:0] count,
                                                  input logic        full,
                                                  input logic        empty,
                                                  input logic [15:0] ovf_cnt);
    console_status_t s;
    s.ovf_cnt   = ovf_cnt;
    s.rsvd      = 6'd0;
    s.empty     = empty;
    s.full      = full;
    s.occupancy = count[7:0];
    return s;
  endfunction

endpackage

// File: rtl/mmio_console_fifo.sv
// Synchronous FIFO; push while full is honoured only together with a pop.
module sync_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_next_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full_o       = (count_q == CNT_W'(DEPTH));
  assign empty_o      = (count_q == CNT_W'(0));
  assign count_o      = count_q;
  assign empty_next_o = (count_d == CNT_W'(0));
  assign pop_data_o   = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_push_s = push_i && (!full_o || pop_i);
    do_pop_s  = pop_i && !empty_o;
    wr_ptr_d  = do_push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = do_pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mmio_console.sv
// Console/halt peripheral: register decode, one-cycle response, TX FIFO,
// overflow counter and sticky halt that waits for the FIFO to drain.
module mmio_console
  import mmio_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] MMIO_BASE = 32'h0002_FFF0,
  localparam int         CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  memory_io_req req,
  output memory_io_rsp rsp_q,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         halt
);

  logic             sel_s, full_wr_s;
  logic             tx_push_s, halt_wr_s, status_rd_s;
  logic             pop_s, push_ok_s, drop_s;
  logic             fifo_full_s, fifo_empty_s, empty_next_s;
  logic [CNT_W-1:0] fifo_count_s;
  logic [15:0]      ovf_q, ovf_d;
  logic             halt_req_q, halt_req_d;
  logic             halt_q, halt_d;
  memory_io_rsp     rsp_d;
  console_status_t  status_s;

  assign sel_s     = req.valid && (req.addr[31:4] == MMIO_BASE[31:4]);
  assign full_wr_s = (req.do_write == FULL_WORD_WRITE);
  assign tx_valid  = !fifo_empty_s;
  assign pop_s     = tx_valid && tx_ready;
  assign push_ok_s = tx_push_s && (!fifo_full_s || pop_s);
  assign drop_s    = tx_push_s && !push_ok_s;
  assign halt      = halt_q;
  assign status_s  = pack_status(32'(fifo_count_s), fifo_full_s, fifo_empty_s, ovf_q);

  always_comb begin
    tx_push_s   = 1'b0;
    halt_wr_s   = 1'b0;
    status_rd_s = 1'b0;
    if (sel_s) begin
      case (req.addr[3:0])
        CONSOLE_STATUS_OFS: status_rd_s = req.do_read;
        CONSOLE_TX_OFS:     tx_push_s   = full_wr_s;
        HALT_OFS:           halt_wr_s   = full_wr_s;
        default:            tx_push_s   = 1'b0;
      endcase
    end else begin
      tx_push_s = 1'b0;
    end
  end

  always_comb begin
    rsp_d = '0;
    if (sel_s) begin
      rsp_d.valid    = 1'b1;
      rsp_d.addr     = req.addr;
      rsp_d.user_tag = req.user_tag;
      rsp_d.data     = status_rd_s ? 32'(status_s) : 32'd0;
    end else begin
      rsp_d.valid = 1'b0;
    end
  end

  // Halt follows the post-update FIFO state so it rises the cycle the last char leaves.
  always_comb begin
    if (drop_s && (ovf_q != 16'hFFFF)) begin
      ovf_d = ovf_q + 16'd1;
    end else begin
      ovf_d = ovf_q;
    end
    halt_req_d = halt_req_q || halt_wr_s;
    halt_d     = halt_req_d && empty_next_s;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_q      <= '0;
      ovf_q      <= 16'd0;
      halt_req_q <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      rsp_q      <= rsp_d;
      ovf_q      <= ovf_d;
      halt_req_q <= halt_req_d;
      halt_q     <= halt_d;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push_ok_s),
    .push_data_i  (req.data[7:0]),
    .pop_i        (pop_s),
    .pop_data_o   (tx_data),
    .full_o       (fifo_full_s),
    .empty_o      (fifo_empty_s),
    .count_o      (fifo_count_s),
    .empty_next_o (empty_next_s)
  );

endmodule

// File: tb/tb_mmio_console.sv
// Directed bench for mmio_console with hand-computed expectations.
module tb_mmio_console;
  import mmio_pkg::*;

  localparam logic [31:0] A_STATUS = 32'h0002_FFF4;
  localparam logic [31:0] A_TX     = 32'h0002_FFF8;
  localparam logic [31:0] A_HALT   = 32'h0002_FFFC;

  logic         clk;
  logic         reset;
  memory_io_req req_s;
  memory_io_rsp rsp_s;
  logic [7:0]   tx_data_s;
  logic         tx_valid_s;
  logic         tx_ready_s;
  logic         halt_s;

  int n_cmp;
  int n_err;
  logic [7:0] got_q[$];

  mmio_console #(.DEPTH(16), .MMIO_BASE(32'h0002_FFF0)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req_s),
    .rsp_q    (rsp_s),
    .tx_data  (tx_data_s),
    .tx_valid (tx_valid_s),
    .tx_ready (tx_ready_s),
    .halt     (halt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one request for one cycle; returns #1 after the consuming edge.
  task automatic bus(input logic [31:0] addr, input logic [31:0] data,
                     input logic rd, input logic [3:0] be, input logic [7:0] tag);
    req_s.valid    = 1'b1;
    req_s.addr     = addr;
    req_s.data     = data;
    req_s.do_read  = rd;
    req_s.do_write = be;
    req_s.user_tag = tag;
    @(posedge clk);
    #1;
    req_s = '0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus(addr, data, 1'b0, 4'b1111, 8'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain(input int cycles);
    got_q.delete();
    tx_ready_s = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      if (tx_valid_s) got_q.push_back(tx_data_s);
      @(posedge clk);
      #1;
    end
    tx_ready_s = 1'b0;
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    reset      = 1'b1;
    req_s      = '0;
    tx_ready_s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    check_val("rst_rsp", 32'(rsp_s.valid) | rsp_s.data | rsp_s.addr, 32'd0);
    check_val("rst_txv", 32'(tx_valid_s), 32'd0);
    check_val("rst_txd", 32'(tx_data_s), 32'd0);
    check_val("rst_halt", 32'(halt_s), 32'd0);

    // In-order stream, each character visible the cycle after its push
    tx_ready_s = 1'b1;
    wr(A_TX, 32'h41);
    check_val("s1_v0", 32'(tx_valid_s), 32'd1);
    check_val("s1_d0", 32'(tx_data_s), 32'h41);
    wr(A_TX, 32'h42);
    check_val("s1_d1", 32'(tx_data_s), 32'h42);
    wr(A_TX, 32'h43);
    check_val("s1_d2", 32'(tx_data_s), 32'h43);
    idle(1);
    check_val("s1_empty", 32'(tx_valid_s), 32'd0);
    check_val("s1_halt", 32'(halt_s), 32'd0);
    tx_ready_s = 1'b0;

    // Overflow: 18 writes into a 16-deep FIFO
    do_reset();
    for (int i = 0; i < 18; i++) wr(A_TX, 32'(8'h60 + i));
    bus(A_STATUS, 32'd0, 1'b1, 4'b0000, 8'd0);
    check_val("s2_status", rsp_s.data, 32'h0002_0110);
    drain(24);
    check_val("s2_ndrain", 32'(got_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < got_q.size(); i++)
      check_val($sformatf("s2_ch%0d", i), 32'(got_q[i]), 32'(8'h60 + i));

    // Push into a full FIFO while popping is accepted
    do_reset();
    for (int i = 0; i < 16; i++) wr(A_TX, 32'(8'h30 + i));
    tx_ready_s = 1'b1;
    wr(A_TX, 32'h5A);
    tx_ready_s = 1'b0;
    bus(A_STATUS, 32'd0, 1'b1, 4'b0000, 8'd0);
    check_val("s3_status", rsp_s.data, 32'h0000_0110);
    drain(24);
    check_val("s3_ndrain", 32'(got_q.size()), 32'd16);
    if (got_q.size() > 0) begin
      check_val("s3_first", 32'(got_q[0]), 32'h31);
      check_val("s3_last", 32'(got_q[got_q.size()-1]), 32'h5A);
    end

    // Halt waits for drain, deasserts on a later push, reasserts after
    do_reset();
    wr(A_TX, 32'h21);
    wr(A_HALT, 32'd1);
    check_val("s4_halt_wait", 32'(halt_s), 32'd0);
    idle(2);
    check_val("s4_halt_wait2", 32'(halt_s), 32'd0);
    tx_ready_s = 1'b1;
    idle(1);
    check_val("s4_halt_up", 32'(halt_s), 32'd1);
    check_val("s4_txv", 32'(tx_valid_s), 32'd0);
    idle(3);
    check_val("s4_halt_keep", 32'(halt_s), 32'd1);
    tx_ready_s = 1'b0;
    wr(A_TX, 32'h22);
    check_val("s4_halt_drop", 32'(halt_s), 32'd0);
    check_val("s4_txd", 32'(tx_data_s), 32'h22);
    tx_ready_s = 1'b1;
    idle(1);
    check_val("s4_halt_again", 32'(halt_s), 32'd1);
    tx_ready_s = 1'b0;

    // Response echo, partial writes, unselected addresses
    do_reset();
    bus(A_STATUS, 32'd0, 1'b1, 4'b0000, 8'd3);
    check_val("s5_valid", 32'(rsp_s.valid), 32'd1);
    check_val("s5_tag", 32'(rsp_s.user_tag), 32'd3);
    check_val("s5_addr", rsp_s.addr, A_STATUS);
    check_val("s5_data", rsp_s.data, 32'h0000_0200);
    idle(1);
    check_val("s5_valid_drop", 32'(rsp_s.valid), 32'd0);
    bus(A_TX, 32'h77, 1'b0, 4'b0011, 8'd5);
    check_val("s5_pw_valid", 32'(rsp_s.valid), 32'd1);
    check_val("s5_pw_data", rsp_s.data, 32'd0);
    check_val("s5_pw_nopush", 32'(tx_valid_s), 32'd0);
    bus(32'h0001_0008, 32'h66, 1'b0, 4'b1111, 8'd1);
    check_val("s5_unsel_rsp", 32'(rsp_s.valid), 32'd0);
    check_val("s5_unsel_push", 32'(tx_valid_s), 32'd0);
    bus(32'h0002_FFF0, 32'h55, 1'b1, 4'b1111, 8'd2);
    check_val("s5_ofs0_data", rsp_s.data, 32'd0);
    check_val("s5_ofs0_push", 32'(tx_valid_s), 32'd0);

    // Reset mid-drain with halt pending; request in reset cycle is ignored
    do_reset();
    for (int i = 0; i < 5; i++) wr(A_TX, 32'(8'h70 + i));
    wr(A_HALT, 32'd1);
    reset          = 1'b1;
    req_s.valid    = 1'b1;
    req_s.addr     = A_STATUS;
    req_s.do_read  = 1'b1;
    req_s.user_tag = 8'd9;
    @(posedge clk);
    #1;
    reset = 1'b0;
    req_s = '0;
    check_val("s6_txv", 32'(tx_valid_s), 32'd0);
    check_val("s6_halt", 32'(halt_s), 32'd0);
    check_val("s6_rsp", 32'(rsp_s.valid), 32'd0);
    idle(1);
    check_val("s6_halt_req_clr", 32'(halt_s), 32'd0);
    bus(A_STATUS, 32'd0, 1'b1, 4'b0000, 8'd0);
    check_val("s6_status", rsp_s.data, 32'h0000_0200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
